// File: rtl/universal_register.sv
// universal_register
//   Parametrised load/clear register with shift, rotate and increment/decrement
//   modes, a clock enable, a registered carry/borrow flag and a zero flag.
//
//   Parameters:
//     WIDTH       - data width (>= 2)
//     CLEAR_VALUE - value loaded on Clear
//     SATURATE    - 0: INC/DEC wrap, 1: INC/DEC saturate at all-ones / zero
//
//   Ports:
//     Clock    - rising-edge clock
//     Clear    - synchronous active-high clear, highest priority
//     Enable   - when low all state holds
//     Mode     - operation select (HOLD/LOAD/SHL/SHR/ROL/ROR/INC/DEC)
//     inData   - parallel load data
//     SerialIn - bit shifted in by SHL/SHR
//     outData  - register contents
//     CarryOut - registered carry, borrow or shifted-out bit
//     Zero     - combinational, high when outData is all zeros
module universal_register #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      CLEAR_VALUE = '0,
  parameter bit                    SATURATE    = 1'b0
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Enable,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] inData,
  input  logic             SerialIn,
  output logic [WIDTH-1:0] outData,
  output logic             CarryOut,
  output logic             Zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic             all_ones, all_zero;

  assign all_ones = &data_q;
  assign all_zero = ~|data_q;

  always_comb begin
    data_d  = data_q;
    carry_d = carry_q;
    case (mode_e'(Mode))
      MODE_LOAD: begin
        data_d  = inData;
        carry_d = 1'b0;
      end
      MODE_SHL: begin
        data_d  = {data_q[WIDTH-2:0], SerialIn};
        carry_d = data_q[WIDTH-1];
      end
      MODE_SHR: begin
        data_d  = {SerialIn, data_q[WIDTH-1:1]};
        carry_d = data_q[0];
      end
      MODE_ROL: begin
        data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        carry_d = data_q[WIDTH-1];
      end
      MODE_ROR: begin
        data_d  = {data_q[0], data_q[WIDTH-1:1]};
        carry_d = data_q[0];
      end
      MODE_INC: begin
        // At all-ones the carry is raised in both wrap and saturate modes;
        // only the data outcome differs.
        if (all_ones) begin
          data_d  = SATURATE ? data_q : '0;
          carry_d = 1'b1;
        end else begin
          data_d  = data_q + ONE;
          carry_d = 1'b0;
        end
      end
      MODE_DEC: begin
        if (all_zero) begin
          data_d  = SATURATE ? data_q : '1;
          carry_d = 1'b1;
        end else begin
          data_d  = data_q - ONE;
          carry_d = 1'b0;
        end
      end
      default: ; // MODE_HOLD
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      data_q  <= CLEAR_VALUE;
      carry_q <= 1'b0;
    end else if (Enable) begin
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end

  assign outData  = data_q;
  assign CarryOut = carry_q;
  assign Zero     = all_zero;

endmodule

// File: tb/tb_universal_register.sv
// Scoreboard bench for universal_register. Four instances share one stimulus
// stream: (W8,CV0,wrap), (W8,CV0,saturate), (W8,CV 0x10,wrap), (W4,CV0,wrap).
// The stimulus process pushes the reference model's expected state after each
// edge into a queue; the monitor pops one entry after every edge and compares.
module tb_universal_register;

  logic       clk = 1'b0;
  logic       Clear, Enable, SerialIn;
  logic [2:0] Mode;
  logic [7:0] inData;

  logic [7:0] o0, o1, o2;
  logic [3:0] o3;
  logic [3:0] co, zo;

  always #5 clk = ~clk;

  universal_register #(.WIDTH(8), .CLEAR_VALUE(8'h00), .SATURATE(1'b0)) u0 (
    .Clock(clk), .Clear(Clear), .Enable(Enable), .Mode(Mode), .inData(inData),
    .SerialIn(SerialIn), .outData(o0), .CarryOut(co[0]), .Zero(zo[0]));
  universal_register #(.WIDTH(8), .CLEAR_VALUE(8'h00), .SATURATE(1'b1)) u1 (
    .Clock(clk), .Clear(Clear), .Enable(Enable), .Mode(Mode), .inData(inData),
    .SerialIn(SerialIn), .outData(o1), .CarryOut(co[1]), .Zero(zo[1]));
  universal_register #(.WIDTH(8), .CLEAR_VALUE(8'h10), .SATURATE(1'b0)) u2 (
    .Clock(clk), .Clear(Clear), .Enable(Enable), .Mode(Mode), .inData(inData),
    .SerialIn(SerialIn), .outData(o2), .CarryOut(co[2]), .Zero(zo[2]));
  universal_register #(.WIDTH(4), .CLEAR_VALUE(4'h0), .SATURATE(1'b0)) u3 (
    .Clock(clk), .Clear(Clear), .Enable(Enable), .Mode(Mode), .inData(inData[3:0]),
    .SerialIn(SerialIn), .outData(o3), .CarryOut(co[3]), .Zero(zo[3]));

  typedef struct {
    int d[4];
    int c[4];
    int hd;   // directed expectation for instance 0 data, -1 if none
    int hc;   // directed expectation for instance 0 carry, -1 if none
  } exp_t;

  exp_t q[$];

  int cfg_w[4]   = '{8, 8, 8, 4};
  int cfg_cv[4]  = '{0, 0, 16, 0};
  int cfg_sat[4] = '{0, 1, 0, 0};
  int m_d[4];
  int m_c[4];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour expressed as plain arithmetic on integers.
  task automatic model_step(input bit clr, input bit en, input int mode,
                            input int din, input bit sin);
    for (int k = 0; k < 4; k++) begin
      int full, top, qv, nd, nc;
      full = (1 << cfg_w[k]) - 1;
      top  = cfg_w[k] - 1;
      qv   = m_d[k];
      nd   = qv;
      nc   = m_c[k];
      if (clr) begin
        nd = cfg_cv[k];
        nc = 0;
      end else if (en) begin
        case (mode)
          1: begin nd = din & full; nc = 0; end
          2: begin nd = ((qv * 2) + sin) % (full + 1); nc = qv / (1 << top); end
          3: begin nd = (qv / 2) + (sin ? (1 << top) : 0); nc = qv % 2; end
          4: begin nd = ((qv * 2) % (full + 1)) + qv / (1 << top); nc = qv / (1 << top); end
          5: begin nd = (qv / 2) + ((qv % 2) ? (1 << top) : 0); nc = qv % 2; end
          6: begin
            if (qv == full) begin nd = cfg_sat[k] ? full : 0; nc = 1; end
            else begin nd = qv + 1; nc = 0; end
          end
          7: begin
            if (qv == 0) begin nd = cfg_sat[k] ? 0 : full; nc = 1; end
            else begin nd = qv - 1; nc = 0; end
          end
          default: ;
        endcase
      end
      m_d[k] = nd;
      m_c[k] = nc;
    end
  endtask

  task automatic step(input bit clr, input bit en, input int mode, input int din,
                      input bit sin, input int hd, input int hc);
    exp_t e;
    @(negedge clk);
    Clear    = clr;
    Enable   = en;
    Mode     = 3'(mode);
    inData   = 8'(din);
    SerialIn = sin;
    model_step(clr, en, mode, din, sin);
    for (int k = 0; k < 4; k++) begin
      e.d[k] = m_d[k];
      e.c[k] = m_c[k];
    end
    e.hd = hd;
    e.hc = hc;
    q.push_back(e);
  endtask

  // Monitor: one entry per edge, checked 1 time unit after the edge.
  initial begin
    exp_t e;
    int   act[4];
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        act[0] = int'(o0);
        act[1] = int'(o1);
        act[2] = int'(o2);
        act[3] = int'(o3);
        for (int k = 0; k < 4; k++) begin
          check($sformatf("u%0d_data", k), act[k], e.d[k]);
          check($sformatf("u%0d_carry", k), int'(co[k]), e.c[k]);
          check($sformatf("u%0d_zero", k), int'(zo[k]), (e.d[k] == 0) ? 1 : 0);
        end
        if (e.hd >= 0) check("directed_data", act[0], e.hd);
        if (e.hc >= 0) check("directed_carry", int'(co[0]), e.hc);
      end
    end
  end

  initial begin
    int waited;
    Clear = 1'b1; Enable = 1'b0; Mode = 3'd0; inData = 8'd0; SerialIn = 1'b0;
    for (int k = 0; k < 4; k++) begin m_d[k] = 0; m_c[k] = 0; end

    // Clear, load, hold
    step(1, 0, 1, 8'h05, 0, 8'h00, 0);
    step(0, 1, 1, 8'h0A, 0, 8'h0A, 0);
    step(0, 0, 1, 8'h05, 0, 8'h0A, 0);
    step(1, 1, 1, 8'h05, 0, 8'h00, 0);
    // Shift and rotate
    step(0, 1, 1, 8'hA5, 0, 8'hA5, 0);
    step(0, 1, 2, 8'h00, 1, 8'h4B, 1);
    step(0, 1, 3, 8'h00, 0, 8'h25, 1);
    step(0, 1, 4, 8'h00, 1, 8'h4A, 0);
    step(0, 1, 5, 8'h00, 1, 8'h25, 0);
    // Wrap-around
    step(0, 1, 1, 8'hFE, 0, 8'hFE, 0);
    step(0, 1, 6, 8'h00, 0, 8'hFF, 0);
    step(0, 1, 6, 8'h00, 0, 8'h00, 1);
    step(0, 1, 7, 8'h00, 0, 8'hFF, 1);
    // Saturation (instance 1 saturates; instance 0 wraps)
    step(0, 1, 1, 8'hFF, 0, 8'hFF, 0);
    step(0, 1, 6, 8'h00, 0, 8'h00, 1);
    step(0, 1, 1, 8'h00, 0, 8'h00, 0);
    step(0, 1, 7, 8'h00, 0, 8'hFF, 1);
    // Clear mid-count (instance 2 runs 11,12,10,11,12)
    step(1, 0, 0, 8'h00, 0, 8'h00, 0);
    step(0, 1, 6, 8'h00, 0, 8'h01, 0);
    step(0, 1, 6, 8'h00, 0, 8'h02, 0);
    step(1, 1, 6, 8'h00, 0, 8'h00, 0);
    step(0, 1, 6, 8'h00, 0, 8'h01, 0);
    step(0, 1, 6, 8'h00, 0, 8'h02, 0);
    // Carry retention (instance 3 wraps F->0 and keeps carry through HOLD)
    step(0, 1, 1, 8'h0F, 0, 8'h0F, 0);
    step(0, 1, 6, 8'h00, 0, 8'h10, 0);
    step(0, 1, 0, 8'hFF, 1, 8'h10, 0);
    step(0, 1, 0, 8'h00, 0, 8'h10, 0);
    step(0, 1, 0, 8'hAA, 1, 8'h10, 0);
    step(0, 1, 1, 8'h03, 0, 8'h03, 0);

    // Randomised traffic with extra weight on boundary data values
    for (int i = 0; i < 400; i++) begin
      int  din, sel;
      bit  clr, en;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: din = 8'hFF;
        1: din = 8'h00;
        2: din = 8'h0F;
        default: din = int'($urandom_range(0, 255));
      endcase
      clr = ($urandom_range(0, 31) == 0);
      en  = ($urandom_range(0, 7) != 0);
      step(clr, en, int'($urandom_range(0, 7)), din, 1'($urandom), -1, -1);
    end

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_register.md
# universal_register

Parametrised successor to the datapath's plain load/clear register. It adds shift, rotate and increment/decrement modes, a clock enable, a registered carry/borrow flag and a zero flag. It sits in the datapath wherever an accumulator, shift register or loop counter is needed, and replaces several fixed-function registers with one block.

## Interface

**Parameters**
- `WIDTH`, default 8: data width in bits; legal values are 2 and above.
- `CLEAR_VALUE`, default 0: value loaded into `outData` on `Clear`; must fit in `WIDTH` bits.
- `SATURATE`, default 0: selects increment/decrement behaviour.
  - 0: increment and decrement wrap around.
  - 1: increment and decrement saturate at all-ones and zero.

**Ports**
- `Clock`, input, 1 bit: the single clock; all state updates on its rising edge.
- `Clear`, input, 1 bit: synchronous, active-high reset/clear; highest priority.
- `Enable`, input, 1 bit: when 0, all state holds regardless of `Mode`.
- `Mode`, input, 3 bits: operation select (see Operation).
- `inData`, input, `WIDTH` bits: parallel load data.
- `SerialIn`, input, 1 bit: bit shifted in during shift modes.
- `outData`, output, `WIDTH` bits: register contents.
- `CarryOut`, output, 1 bit: registered carry, borrow or shifted-out bit.
- `Zero`, output, 1 bit: combinational; 1 when `outData` is all zeros.

## Operation

**Priority at each rising `Clock` edge**
1. `Clear` = 1: `outData` <= `CLEAR_VALUE` and `CarryOut` <= 0, regardless of `Enable`, `Mode` or `inData`.
2. `Enable` = 0: `outData` and `CarryOut` hold.
3. Otherwise `Mode` selects the operation. `Q` is the current `outData`; `W` = `WIDTH`.

**Modes**
- 000 HOLD: `outData` holds; `CarryOut` holds.
- 001 LOAD: `outData` <= `inData`; `CarryOut` <= 0.
- 010 SHL: `outData` <= {`Q[W-2:0]`, `SerialIn`}; `CarryOut` <= `Q[W-1]`.
- 011 SHR: `outData` <= {`SerialIn`, `Q[W-1:1]`}; `CarryOut` <= `Q[0]`.
- 100 ROL: `outData` <= {`Q[W-2:0]`, `Q[W-1]`}; `CarryOut` <= `Q[W-1]`.
- 101 ROR: `outData` <= {`Q[0]`, `Q[W-1:1]`}; `CarryOut` <= `Q[0]`.
- 110 INC:
  - `Q` not all-ones: `outData` <= `Q`+1; `CarryOut` <= 0.
  - `Q` all-ones, `SATURATE`=0: `outData` <= 0; `CarryOut` <= 1.
  - `Q` all-ones, `SATURATE`=1: `outData` holds all-ones; `CarryOut` <= 1.
- 111 DEC:
  - `Q` not zero: `outData` <= `Q`-1; `CarryOut` <= 0.
  - `Q` = 0, `SATURATE`=0: `outData` <= all-ones; `CarryOut` <= 1 (borrow).
  - `Q` = 0, `SATURATE`=1: `outData` holds 0; `CarryOut` <= 1.

**Arithmetic and flags**
- All arithmetic is unsigned, modulo 2^`WIDTH`.
- No X propagation from `SerialIn` when the mode is not SHL or SHR.
- `Zero` = ~|`outData`, purely combinational from the register; no extra state.

## Timing

- Latency: one cycle. Inputs sampled at edge N are visible on `outData` and `CarryOut` after edge N.
- Reset values after any edge with `Clear` = 1: `outData` = `CLEAR_VALUE`, `CarryOut` = 0, `Zero` = (`CLEAR_VALUE` == 0).
- Before the first `Clear`, outputs are undefined; the bench must assert `Clear` first.
- `Clear` asserted mid-sequence (for example during repeated INC) takes effect on that edge. The operation resumes from `CLEAR_VALUE` on the first edge with `Clear` = 0.
- `Clear` and `Enable` both high: `Clear` wins.
- `Mode` changes take effect edge-by-edge; no multi-cycle operations and no internal state beyond `outData` and `CarryOut`.
- `inData` changes between edges have no effect.

## Test plan

All scenarios use `WIDTH`=8, `CLEAR_VALUE`=0 and `SATURATE`=0 unless stated.

1. **Clear, load and hold.** Apply `Clear`=1 with `inData`=5 -> `outData`=0, `Zero`=1. Then LOAD 8'd10 -> `outData`=10, `Zero`=0. Then `Enable`=0 with `Mode`=LOAD and `inData`=5 -> stays 10. Then `Clear`=1 with `Mode`=LOAD -> 0.
2. **Shift and rotate.** LOAD 8'hA5, then SHL with `SerialIn`=1 -> 8'h4B, `CarryOut`=1. Then SHR with `SerialIn`=0 -> 8'h25, `CarryOut`=1. Then ROL -> 8'h4A, `CarryOut`=0. Then ROR -> 8'h25, `CarryOut`=0.
3. **Wrap-around.** LOAD 8'hFE, then INC x2 -> 8'hFF (`CarryOut`=0), then 8'h00 (`CarryOut`=1, `Zero`=1). Then DEC -> 8'hFF, `CarryOut`=1.
4. **Saturation.** Use `SATURATE`=1. LOAD 8'hFF, INC -> stays 8'hFF, `CarryOut`=1. LOAD 0, DEC -> stays 0, `CarryOut`=1, `Zero`=1.
5. **Clear mid-count.** Use `CLEAR_VALUE`=8'h10. Run INC for 5 cycles from 8'h10, assert `Clear` on the 3rd edge -> sequence 11, 12, 10, 11, 12. `CarryOut`=0 throughout.
6. **Carry retention.** Use `WIDTH`=4. LOAD 4'hF, INC -> 0 with `CarryOut`=1. Then HOLD for 3 cycles -> `CarryOut` stays 1. Then LOAD 4'h3 -> `CarryOut`=0.
